// File: rtl/sd_audio_defs_pkg.sv
// Shared definitions for the SD audio path.
// Contents:
//   pacer_state_e   - pcm_pacer FSM encodings, also driven onto the LED state port
//   PCM_MIDSCALE    - offset-binary zero level presented to dac16
//   CLK_DIV_DEFAULT - clk96m cycles per 48 kHz sample tick
//   UNITY_VOL       - volume code for gain 1.0 (gain = volume / 128)
package sd_audio_defs;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPrime    = 2'd1,
    StPlay     = 2'd2,
    StUnderrun = 2'd3
  } pacer_state_e;

  localparam logic [15:0] PCM_MIDSCALE    = 16'h8000;
  localparam int unsigned CLK_DIV_DEFAULT = 2000;
  localparam logic [7:0]  UNITY_VOL       = 8'h80;

endpackage

// File: rtl/pcm_scale.sv
// Output stage of pcm_pacer: volume multiply, arithmetic shift, saturation and
// conversion to offset binary, registered once.
// Ports:
//   clk96m, rst - system clock, synchronous active-high reset
//   valid_i     - data_i/volume_i hold a sample to be scaled this cycle
//   flush_i     - drop any sample in flight and force midscale
//   data_i      - signed two's-complement sample
//   volume_i    - unsigned gain code, gain = volume_i / 128
//   pcm_o       - offset-binary sample, held between updates
//   strobe_o    - one-cycle pulse on the cycle pcm_o takes a new sample
module pcm_scale
  import sd_audio_defs::*;
(
  input  logic        clk96m,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [15:0] data_i,
  input  logic [7:0]  volume_i,
  output logic [15:0] pcm_o,
  output logic        strobe_o
);

  logic signed [24:0] prod;
  logic signed [24:0] shifted;
  logic        [15:0] sat;
  logic        [15:0] pcm_q;
  logic               strobe_q;

  // Zero-extend volume so the product stays signed; |prod| < 2^23 so 25 bits never overflow.
  assign prod    = $signed(data_i) * $signed({1'b0, volume_i});
  assign shifted = prod >>> 7;

  always_comb begin
    sat = shifted[15:0];
    if (shifted > 25'sd32767) begin
      sat = 16'h7FFF;
    end else if (shifted < -25'sd32768) begin
      sat = 16'h8000;
    end
  end

  always_ff @(posedge clk96m) begin
    if (rst || flush_i) begin
      pcm_q    <= PCM_MIDSCALE;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= valid_i;
      if (valid_i) begin
        pcm_q <= sat ^ PCM_MIDSCALE;
      end
    end
  end

  assign pcm_o    = pcm_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/pcm_pacer.sv
// Sample-rate pacer between the SDFeed sample FIFO and dac16.
// Divides clk96m to one tick every CLK_DIV cycles, pops one sample per tick,
// scales it by volume and presents offset-binary PCM. Primes on FIFO half-full,
// holds the last sample on underrun and counts underrun ticks.
// Tick on cycle T: fifo_rd_en on T+1, fifo_data/volume used on T+2, pcm and
// sample_strobe on T+3.
// Build option: define PCM_PACER_UNDERRUN_CNT_EN to implement the saturating
// underrun counter; otherwise underrun_cnt is tied to zero.
// Ports:
//   clk96m, rst    - 96 MHz clock, synchronous active-high reset
//   enable         - playback enable; low returns to IDLE and discards in-flight data
//   volume         - unsigned gain code, gain = volume / 128
//   fifo_data      - signed sample, valid the cycle after fifo_rd_en
//   fifo_empty     - FIFO empty flag
//   fifo_halffull  - FIFO half-full flag, used to leave PRIME
//   fifo_rd_en     - one-cycle pop strobe
//   pcm            - offset-binary sample to dac16
//   sample_strobe  - one-cycle pulse when pcm updates
//   underrun_cnt   - saturating count of underrun ticks
//   state          - current FSM state, for LEDs
module pcm_pacer
  import sd_audio_defs::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic        clk96m,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  volume,
  input  logic [15:0] fifo_data,
  input  logic        fifo_empty,
  input  logic        fifo_halffull,
  output logic        fifo_rd_en,
  output logic [15:0] pcm,
  output logic        sample_strobe,
  output logic [7:0]  underrun_cnt,
  output logic [1:0]  state
);

  localparam int unsigned    DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  pacer_state_e    state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            rd_q, rd_d;
  logic            vld_q, vld_d;
  logic            tick;
  logic            cnt_inc;

  assign tick = (state_q != StIdle) && (div_q == DivMax);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rd_d    = 1'b0;
    vld_d   = rd_q;
    cnt_inc = 1'b0;

    // Divider sits at zero in IDLE, so entering PRIME always starts a fresh period.
    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    unique case (state_q)
      StIdle: begin
        state_d = StPrime;
      end
      StPrime: begin
        if (fifo_halffull) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tick) begin
          if (!fifo_empty) begin
            rd_d = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            state_d = StUnderrun;
          end
        end
      end
      StUnderrun: begin
        if (tick) begin
          if (!fifo_empty) begin
            rd_d    = 1'b1;
            state_d = StPlay;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Disable overrides everything, including a pop already issued.
    if (!enable) begin
      state_d = StIdle;
      div_d   = '0;
      rd_d    = 1'b0;
      vld_d   = 1'b0;
      cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge clk96m) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
    end
  end

`ifdef PCM_PACER_UNDERRUN_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk96m) begin
    if (rst) begin
      cnt_q <= 8'h00;
    end else if (cnt_inc && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'h01;
    end
  end

  assign underrun_cnt = cnt_q;
`else
  logic unused_cnt_inc;
  assign unused_cnt_inc = cnt_inc;
  assign underrun_cnt   = 8'h00;
`endif

  pcm_scale u_scale (
    .clk96m   (clk96m),
    .rst      (rst),
    .valid_i  (vld_q),
    .flush_i  (!enable),
    .data_i   (fifo_data),
    .volume_i (volume),
    .pcm_o    (pcm),
    .strobe_o (sample_strobe)
  );

  assign fifo_rd_en = rd_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pcm_pacer.sv
// Self-checking bench for pcm_pacer with a shortened divider. A queue models the
// sample FIFO; a schedule-based reference model predicts every registered output
// each cycle from the block's rules, and directed scenarios pin literal values.
module tb_pcm_pacer;

  localparam int unsigned DIV  = 16;
  localparam int          HALF = 4;

  logic        clk96m = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  volume;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_halffull;
  logic        fifo_rd_en;
  logic [15:0] pcm;
  logic        sample_strobe;
  logic [7:0]  underrun_cnt;
  logic [1:0]  state;

  always #5 clk96m = ~clk96m;

  pcm_pacer #(.CLK_DIV(DIV)) dut (
    .clk96m        (clk96m),
    .rst           (rst),
    .enable        (enable),
    .volume        (volume),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_halffull (fifo_halffull),
    .fifo_rd_en    (fifo_rd_en),
    .pcm           (pcm),
    .sample_strobe (sample_strobe),
    .underrun_cnt  (underrun_cnt),
    .state         (state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] fq[$];
  bit          drv_rst = 1'b1;
  bit          drv_en  = 1'b0;
  logic [7:0]  drv_vol = 8'h80;

  // Reference model: state per cycle, tick schedule relative to PRIME entry,
  // and at most one pop in flight (tick cycle + sample).
  int m_st        = 0;
  int m_cnt       = 0;
  int prime_start = 0;
  int e_pcm       = 32768;
  int e_strobe    = 0;
  int e_rd        = 0;
  int e_state     = 0;
  bit pend        = 1'b0;
  int pend_tick   = 0;
  int pend_sample = 0;

  bit          rd_prev    = 1'b0;
  bit          got_strobe = 1'b0;
  logic [15:0] got_pcm    = 16'h0;
  int          last_rd    = -1;
  bit          track      = 1'b0;
  logic [15:0] v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // gain = vol/128 with floor, clamp to 16-bit signed, then offset binary.
  function automatic int scale(input int raw, input int vol);
    int s;
    int q;
    s = (raw >= 32768) ? raw - 65536 : raw;
    q = (s * vol) >>> 7;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q + 32768;
  endfunction

  task automatic model_step();
    int nst;
    bit tk;
    e_strobe = 0;
    e_rd     = 0;
    if (drv_rst) begin
      m_st  = 0;
      m_cnt = 0;
      pend  = 1'b0;
      e_pcm = 32768;
    end else if (!drv_en) begin
      m_st  = 0;
      pend  = 1'b0;
      e_pcm = 32768;
    end else begin
      nst = m_st;
      tk  = (m_st != 0) && (((cyc - prime_start) % DIV) == DIV - 1);
      if (pend && (cyc == pend_tick + 2)) begin
        e_pcm    = scale(pend_sample, int'(drv_vol));
        e_strobe = 1;
        pend     = 1'b0;
      end
      case (m_st)
        0: begin
          nst         = 1;
          prime_start = cyc + 1;
        end
        1: if (fq.size() >= HALF) nst = 2;
        default: begin
          if (tk) begin
            if (fq.size() > 0) begin
              pend        = 1'b1;
              pend_tick   = cyc;
              pend_sample = int'(fq[0]);
              e_rd        = 1;
              nst         = 2;
            end else begin
              if (m_cnt < 255) m_cnt++;
              nst = 3;
            end
          end
        end
      endcase
      m_st = nst;
    end
    e_state = m_st;
  endtask

  task automatic cycle();
    fifo_empty    = (fq.size() == 0);
    fifo_halffull = (fq.size() >= HALF);
    rst           = drv_rst;
    enable        = drv_en;
    volume        = drv_vol;
    model_step();
    @(posedge clk96m);
    #1;
    cyc++;
    if (rd_prev) begin
      if (fq.size() > 0) fifo_data = fq.pop_front();
      else check("pop_on_empty", 32'd1, 32'd0);
    end
    check("pcm", pcm, e_pcm);
    check("sample_strobe", sample_strobe, e_strobe);
    check("fifo_rd_en", fifo_rd_en, e_rd);
    check("state", state, e_state);
`ifdef PCM_PACER_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, m_cnt);
`else
    check("underrun_cnt", underrun_cnt, 0);
`endif
    rd_prev = fifo_rd_en;
    if (sample_strobe) begin
      got_strobe = 1'b1;
      got_pcm    = pcm;
    end
    if (track && fifo_rd_en) begin
      if (last_rd >= 0) check("pop_spacing", cyc - last_rd, DIV);
      last_rd = cyc;
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic wait_strobe(input string name, input int budget, output logic [15:0] val);
    got_strobe = 1'b0;
    for (int i = 0; i < budget && !got_strobe; i++) cycle();
    if (!got_strobe) check({name, "_timeout"}, 32'd0, 32'd1);
    val = got_pcm;
  endtask

  task automatic wait_rd(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      seen = rd_prev;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [7:0] vol_tab[4];

  initial begin
    fifo_data     = 16'h0000;
    rst           = 1'b1;
    enable        = 1'b0;
    volume        = 8'h80;
    fifo_empty    = 1'b1;
    fifo_halffull = 1'b0;
    vol_tab[0] = 8'h00; vol_tab[1] = 8'h80; vol_tab[2] = 8'hFF; vol_tab[3] = 8'h40;

    // Pin the model's scaling rule with hand-computed values.
    check("model_1000_x80", scale(32'h1000, 8'h80), 16'h9000);
    check("model_F000_x80", scale(32'hF000, 8'h80), 16'h7000);
    check("model_7FFF_xFF", scale(32'h7FFF, 8'hFF), 16'hFFFF);
    check("model_8000_xFF", scale(32'h8000, 8'hFF), 16'h0000);
    check("model_1234_x00", scale(32'h1234, 8'h00), 16'h8000);

    // Reset then long disabled stretch.
    drv_rst = 1'b1;
    run(3);
    check("rst_pcm", pcm, 16'h8000);
    check("rst_state", state, 2'd0);
    drv_rst = 1'b0;
    run(200);
    check("idle_pcm", pcm, 16'h8000);
    check("idle_state", state, 2'd0);

    // Prime and play at unity gain, then drain into underrun.
    fq.push_back(16'h1000);
    fq.push_back(16'hF000);
    fq.push_back(16'h2000);
    fq.push_back(16'h0100);
    drv_vol = 8'h80;
    track   = 1'b1;
    last_rd = -1;
    drv_en  = 1'b1;
    wait_strobe("s1", 60, v);
    check("pcm_s1", v, 16'h9000);
    wait_strobe("s2", 40, v);
    check("pcm_s2", v, 16'h7000);
    wait_strobe("s3", 40, v);
    check("pcm_s3", v, 16'hA000);
    wait_strobe("s4", 40, v);
    check("pcm_s4", v, 16'h8100);
    track = 1'b0;
    run(5 * DIV);
    check("underrun_state", state, 2'd3);
    check("underrun_hold", pcm, 16'h8100);
`ifdef PCM_PACER_UNDERRUN_CNT_EN
    check("underrun_cnt5", underrun_cnt, 8'd5);
`else
    check("underrun_cnt_off", underrun_cnt, 8'd0);
`endif

    // Refill and volume extremes.
    drv_vol = 8'hFF;
    fq.push_back(16'h7FFF);
    wait_strobe("sat_pos", 40, v);
    check("pcm_sat_pos", v, 16'hFFFF);
    check("refill_state", state, 2'd2);
    fq.push_back(16'h8000);
    wait_strobe("sat_neg", 40, v);
    check("pcm_sat_neg", v, 16'h0000);
    drv_vol = 8'h00;
    fq.push_back(16'h1234);
    wait_strobe("vol0", 40, v);
    check("pcm_vol0", v, 16'h8000);

    // Long underrun drives the counter into saturation.
    run(300 * DIV + 8);
`ifdef PCM_PACER_UNDERRUN_CNT_EN
    check("underrun_sat", underrun_cnt, 8'hFF);
`else
    check("underrun_sat_off", underrun_cnt, 8'h00);
`endif

    // Drop enable on T+1 of a pop.
    drv_vol = 8'h80;
    for (int i = 0; i < 4; i++) fq.push_back(16'h4000);
    wait_rd("rd_en_drop", 40);
    drv_en = 1'b0;
    run(1);
    check("drop_state", state, 2'd0);
    check("drop_pcm", pcm, 16'h8000);
    check("drop_strobe", sample_strobe, 1'b0);
    run(1);
    check("drop_strobe2", sample_strobe, 1'b0);

    // Same point with rst instead.
    fq.push_back(16'h5000);
    fq.push_back(16'h5000);
    drv_en = 1'b1;
    wait_rd("rd_rst", 80);
    drv_rst = 1'b1;
    run(1);
    check("rst_mid_state", state, 2'd0);
    check("rst_mid_pcm", pcm, 16'h8000);
    check("rst_mid_cnt", underrun_cnt, 8'h00);
    check("rst_mid_strobe", sample_strobe, 1'b0);
    run(1);
    check("rst_mid_strobe2", sample_strobe, 1'b0);
    check("rst_mid_rd", fifo_rd_en, 1'b0);
    drv_rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drv_rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 399) == 0) drv_en = !drv_en;
      if (!drv_en && $urandom_range(0, 19) == 0) drv_en = 1'b1;
      if ($urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 1) == 0) drv_vol = vol_tab[$urandom_range(0, 3)];
        else drv_vol = 8'($urandom);
      end
      if (fq.size() < 12 && $urandom_range(0, DIV + 4) == 0) fq.push_back(16'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcm_pacer.md
# pcm_pacer

Sample-rate pacing and output stage between the SDFeed sample FIFO and the dac16 modulator. Divides clk96m down to an exact 48 kHz sample tick, pops one 16-bit signed sample per tick from the FIFO, applies an 8-bit volume with saturation, and presents offset-binary PCM to dac16. It primes on FIFO half-full, holds the last sample on underrun, and reports underrun events.

## Interface
- CLK_DIV, 2000, clk96m cycles per sample tick (96 MHz / 2000 = 48 kHz).
- UNITY_VOL, 8'h80, volume code giving gain 1.0.
- clk96m  in  1  system clock, 96 MHz.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  playback enable, level.
- volume  in  8  unsigned gain, gain = volume/128.
- fifo_data  in  16  signed two's-complement sample; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_halffull  in  1  FIFO half-full flag.
- fifo_rd_en  out  1  one-cycle pop strobe.
- pcm  out  16  offset-binary sample to dac16.
- sample_strobe  out  1  one-cycle pulse when pcm updates.
- underrun_cnt  out  8  saturating underrun count.
- state  out  2  current FSM state, for LEDs.

## Operation
- States: IDLE=2'd0, PRIME=2'd1, PLAY=2'd2, UNDERRUN=2'd3.
- IDLE: divider held at 0, pcm = 16'h8000 (midscale), no reads. Exits to PRIME when enable=1.
- PRIME: divider runs, no reads, pcm held. Goes to PLAY on the first cycle with fifo_halffull=1.
- PLAY: on each tick with fifo_empty=0, pop one sample. On a tick with fifo_empty=1: no pop, pcm held, underrun_cnt increments, go to UNDERRUN.
- UNDERRUN: on each tick with fifo_empty=1, hold pcm and increment underrun_cnt again. On a tick with fifo_empty=0, pop and return to PLAY.
- enable=0 in any state: next cycle go to IDLE. In-flight pipeline data is discarded, pcm = 16'h8000, and sample_strobe is not raised.
- Scaling: prod = signed(fifo_data) × {1'b0,volume}, 25-bit signed. s = prod >>> 7 (arithmetic). Saturate to [-32768, 32767]. pcm = sat ^ 16'h8000.
- volume=0 gives pcm=16'h8000. volume=255 saturates at full scale.
- underrun_cnt saturates at 8'hFF. It is cleared only by rst; enable does not clear it.
- fifo_rd_en is never asserted unless fifo_empty was 0 on the tick cycle. This block is the only reader, so empty cannot assert in between.

## Timing
- Divider counts 0..CLK_DIV-1 and ticks on count CLK_DIV-1. Tick period is exactly CLK_DIV cycles; the divider is zeroed on entering PRIME from IDLE.
- Tick on cycle T gives: fifo_rd_en=1 on T+1; fifo_data captured on T+2; pcm updated and sample_strobe=1 on T+3. Latency is fixed at 3 cycles.
- An underrun tick produces no sample_strobe. underrun_cnt updates on T+1.
- Reset values: state=IDLE, fifo_rd_en=0, sample_strobe=0, underrun_cnt=0, pcm=16'h8000, divider=0.
- rst during the read pipeline: everything returns to reset values the next cycle and no further pop is issued.
- volume is sampled on T+2. A change mid-pipeline affects the next sample only.

## Configuration
- PCM_PACER_UNDERRUN_CNT_EN defined: underrun counter is implemented as described.
- PCM_PACER_UNDERRUN_CNT_EN undefined: underrun_cnt is tied to 8'h00 and no counter register exists. Hold-last-sample and the UNDERRUN state are unchanged.

## Structure
- Shared package/include (sd_audio_defs):
  - state encodings;
  - PCM_MIDSCALE = 16'h8000;
  - default CLK_DIV = 2000;
  - UNITY_VOL = 8'h80.
- Sub-module pcm_scale: registered multiply, shift, saturate and offset conversion. One-cycle latency, stage T+2 to T+3.
- FSM, divider and read strobe live in pcm_pacer.

## Test plan
- Reset, enable=0 for 5000 cycles → pcm=16'h8000, fifo_rd_en never 1, state=0.
- enable=1, FIFO preloaded half-full with samples 16'h1000, 16'hF000, volume=8'h80 → PRIME→PLAY. Pops exactly 2000 cycles apart. pcm = 16'h9000 then 16'h7000, each 3 cycles after the tick.
- volume=8'hFF with sample 16'h7FFF → pcm=16'hFFFF (saturated). Sample 16'h8000 → pcm=16'h0000. volume=0 → pcm=16'h8000.
- FIFO drained during PLAY with last sample 16'h0100 → pcm holds 16'h8100, state=3, underrun_cnt increments once per tick. Refilling → next tick pops and state=2.
- 300 consecutive underrun ticks → underrun_cnt=8'hFF. With the macro undefined → underrun_cnt stays 8'h00.
- enable dropped on cycle T+1 of a pop → no sample_strobe, pcm=16'h8000 and state=0 next cycle. rst asserted at the same point gives the same result plus underrun_cnt=0.
